// File: rtl/tx_filter.sv
// Polyphase transmit shaping filter: OS-times upsampling of 2-bit mapped symbols
// convolved with a loadable OS*NBAUD-tap set. Define TX_FILTER_SAT_EN to clamp the output instead of wrapping.
module tx_filter #(
  parameter int OS    = 4,
  parameter int NBAUD = 6,
  parameter int CW    = 8,
  parameter int OW    = 10,
  parameter int SHIFT = 0
) (
  input  logic                              clock,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic                              i_valid,
  input  logic [1:0]                        i_mappedx,
  input  logic                              i_coef_we,
  input  logic [$clog2(OS*NBAUD)-1:0]       i_coef_addr,
  input  logic signed [CW-1:0]              i_coef_data,
  output logic signed [OW-1:0]              o_filterx,
  output logic                              o_valid
);

  localparam int NTAPS = OS * NBAUD;
  localparam int AW    = $clog2(NTAPS);
  localparam int FW    = CW + 2 + $clog2(NBAUD);
  localparam int PW    = (OS > 1) ? $clog2(OS) : 1;

  logic signed [CW-1:0] coef [NTAPS];
  logic [1:0]           sym      [NBAUD];
  logic [1:0]           sym_next [NBAUD];
  logic [PW-1:0]        phase;
  logic [PW-1:0]        phase_next;

  logic signed [FW-1:0] acc;
  logic signed [FW-1:0] acc_sh;
  logic signed [CW-1:0] tap;
  logic signed [FW-1:0] tap_ext;
  logic signed [OW-1:0] res_next;
  logic signed [OW-1:0] res_q;
  logic                 valid_q;

  // Coefficient store: not reset, writable regardless of enable/strobe.
  always_ff @(posedge clock) begin
    if (i_coef_we && (int'(i_coef_addr) < NTAPS)) begin
      coef[i_coef_addr] <= i_coef_data;
    end
  end

  assign phase_next = (phase == PW'(OS - 1)) ? '0 : phase + 1'b1;

  // New symbol enters on phase 0 and contributes to the same strobe's sum.
  always_comb begin
    sym_next = sym;
    if (phase == '0) begin
      sym_next[0] = i_mappedx;
      for (int k = 1; k < NBAUD; k++) begin
        sym_next[k] = sym[k-1];
      end
    end
  end

  // Symbols are in {-2,-1,0,+1}, so each product is a negate and/or shift.
  always_comb begin
    acc     = '0;
    tap     = '0;
    tap_ext = '0;
    for (int k = 0; k < NBAUD; k++) begin
      tap     = coef[AW'(k * OS) + AW'(phase)];
      tap_ext = {{(FW-CW){tap[CW-1]}}, tap};
      case (sym_next[k])
        2'b01:   acc = acc + tap_ext;
        2'b11:   acc = acc - tap_ext;
        2'b10:   acc = acc - (tap_ext <<< 1);
        default: acc = acc;
      endcase
    end
  end

  assign acc_sh = acc >>> SHIFT;

`ifdef TX_FILTER_SAT_EN
  localparam logic signed [FW-1:0] SAT_MAX = FW'((2 ** (OW - 1)) - 1);
  localparam logic signed [FW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    res_next = OW'(acc_sh);
    if (acc_sh > SAT_MAX) begin
      res_next = OW'(SAT_MAX);
    end else if (acc_sh < SAT_MIN) begin
      res_next = OW'(SAT_MIN);
    end
  end
`else
  assign res_next = OW'(acc_sh);
`endif

  // Two stages: sum registered at the strobe edge, presented one edge later.
  // The output stage freezes with enable so a pending sample is never lost.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase     <= '0;
      for (int k = 0; k < NBAUD; k++) begin
        sym[k] <= '0;
      end
      res_q     <= '0;
      valid_q   <= 1'b0;
      o_filterx <= '0;
      o_valid   <= 1'b0;
    end else if (i_enable) begin
      valid_q <= i_valid;
      o_valid <= valid_q;
      if (valid_q) begin
        o_filterx <= res_q;
      end
      if (i_valid) begin
        phase <= phase_next;
        sym   <= sym_next;
        res_q <= res_next;
      end
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: doc/tx_filter.md
# tx_filter

Polyphase transmit shaping filter that sits directly downstream of the mapper. It consumes the 2-bit mapped symbol stream, upsamples it by OS, and convolves it with a runtime-loadable OS·NBAUD-tap coefficient set. It emits one signed filtered sample per sample-rate strobe to the channel/DAC side. Because symbols are small two's-complement integers, each tap product is a shift/add, so the datapath is multiplier-free.

## Interface
- OS, 4, oversampling factor; one symbol is consumed every OS strobes.
- NBAUD, 6, filter span in symbols; NTAPS = OS·NBAUD = 24.
- CW, 8, coefficient width, signed.
- OW, 10, output width, signed.
- SHIFT, 0, arithmetic right shift applied to the accumulator before narrowing to OW bits.
- clock  in  1  single system clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global enable; when low, all state freezes.
- i_valid  in  1  sample-rate strobe; one output sample is produced per strobe.
- i_mappedx  in  2  mapped symbol, two's complement (01=+1, 11=−1, 00=0, 10=−2); sampled only on phase-0 strobes.
- i_coef_we  in  1  coefficient write enable.
- i_coef_addr  in  $clog2(NTAPS)  coefficient index, 0..NTAPS−1.
- i_coef_data  in  CW  signed coefficient value.
- o_filterx  out  OW  signed filtered sample.
- o_valid  out  1  one-cycle pulse marking a new o_filterx.

## Operation
- Strobe: i_enable && i_valid && !i_reset.
- Phase counter p runs 0..OS−1, advances by one per strobe, and wraps OS−1 → 0.
- Symbol register sym[0..NBAUD−1] shifts only on a phase-0 strobe: sym[0] ← i_mappedx and sym[k] ← sym[k−1].
- On each strobe, acc = Σk sym'[k]·coef[k·OS+p].
  - sym' is the register contents after any shift in that same strobe, so the new symbol contributes immediately.
- Full-precision accumulator width is FW = CW+2+$clog2(NBAUD); no internal overflow is possible.
- Narrowing: t = acc >>> SHIFT, then reduced to OW bits as defined in Configuration.
- Coefficient RAM: on i_coef_we, coef[i_coef_addr] ← i_coef_data.
  - Writes are accepted regardless of i_enable and i_valid.
  - Addresses ≥ NTAPS are ignored.
- Read/write collision: a strobe and a write to the same tap in one cycle use the old value; the new value is used from the next cycle.
- Coefficients are not affected by reset. The bench must load all NTAPS taps before the first strobe.
- i_enable low: p, sym and o_filterx hold; o_valid is 0.
- i_valid low with i_enable high: no state change; o_valid is 0.

## Timing
- Reset values: o_filterx=0, o_valid=0, p=0, sym[*]=0.
- Reset takes priority over strobe and enable, but not over coefficient writes.
- Latency: a strobe at edge t produces o_filterx and o_valid=1 after edge t+1. o_valid falls at the next edge unless another strobe occurs.
- Back-to-back strobes every cycle are supported at full throughput, one sample per clock.
- Reset mid-operation: all in-flight state is discarded. The first strobe after reset is phase 0 and samples i_mappedx.

## Configuration
- TX_FILTER_SAT_EN defined: t is clamped to [−2^(OW−1), 2^(OW−1)−1].
- TX_FILTER_SAT_EN undefined: the upper bits of t are discarded (two's-complement wrap); the low OW bits are output.

## Test plan
- Impulse: load coef[n]=n+1; after reset, drive a +1 symbol then 0 symbols with a strobe every cycle → o_filterx reads 1,2,…,24, then 0; one o_valid per strobe, each one cycle after its strobe.
- Negative impulse: same setup with −1 (11) as the first symbol → o_filterx reads −1,−2,…,−24, then 0.
- Saturation/wrap: all coefficients 127, constant symbol −2 → steady state −512 with TX_FILTER_SAT_EN, −500 without. Constant symbol +1 → 511 with TX_FILTER_SAT_EN, −262 without.
- Enable gating: during the impulse test, drop i_enable for 3 cycles at phase 2 → o_valid=0 and o_filterx held for those cycles; the output sequence then resumes at the next value with no skips.
- Reset mid-stream: assert i_reset for one cycle at phase 2 → after the next edge o_valid=0, o_filterx=0 and p=0. Coefficients are retained, so re-running the impulse gives 1..24 again.
- Write collision: strobe at phase 0 while writing coef[0]=50 (old value 1), with an impulse symbol → that output is 1; a repeated impulse after the write gives a first output of 50.
